// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - parametrised memory-mapped GPIO register bank; optional input debounce under GPIO_DEBOUNCE_EN
module gpio_bank #(
  parameter int NUM_IN          = 2,
  parameter int NUM_OUT         = 2,
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [3:0]               waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [3:0]               raddr,
  output logic [WIDTH-1:0]         rdata,
  input  logic [NUM_IN*WIDTH-1:0]  in_pins,
  output logic [NUM_OUT*WIDTH-1:0] out_pins,
  output logic [NUM_IN-1:0]        chg_flag,
  output logic                     irq
);

  localparam logic [3:0] ADDR_MASK = 4'hE;
  localparam logic [3:0] ADDR_FLAG = 4'hF;

  logic [NUM_IN*WIDTH-1:0]  sync1;
  logic [NUM_IN*WIDTH-1:0]  sync2;
  logic [NUM_IN*WIDTH-1:0]  acc_flat;
  logic [NUM_IN-1:0]        set_vec;
  logic [NUM_IN-1:0]        clr_vec;
  logic [NUM_IN-1:0]        wdata_low;
  logic [NUM_IN-1:0]        irq_mask;
  logic [NUM_OUT*WIDTH-1:0] out_regs;
  logic [WIDTH-1:0]         rd_next;

  // Two-flop synchroniser on the raw asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_pins;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
      logic [WIDTH-1:0] s2;
      logic [WIDTH-1:0] nxt;
      logic [WIDTH-1:0] acc;
      logic             load;

      assign s2 = sync2[i*WIDTH +: WIDTH];

`ifdef GPIO_DEBOUNCE_EN
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0] cand;
      logic [CW-1:0]    cnt;

      // Candidate tracks sync2; the counter measures how long it has stayed put
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand <= '0;
          cnt  <= '0;
        end else if (s2 != cand) begin
          cand <= s2;
          cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign load = (s2 == cand) && (cnt == CNT_MAX);
      assign nxt  = cand;
`else
      assign load = 1'b1;
      assign nxt  = s2;
`endif

      assign set_vec[i]                 = load && (nxt != acc);
      assign acc_flat[i*WIDTH +: WIDTH] = acc;

      // Accepted value; only a genuine change raises the channel flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    acc <= '0;
        else if (load) acc <= nxt;
      end
    end
  endgenerate

  assign wdata_low = NUM_IN'(wdata);
  assign clr_vec   = (we && waddr == ADDR_FLAG) ? wdata_low : '0;

  // Sticky change flags: a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg_flag <= '0;
    else        chg_flag <= (chg_flag & ~clr_vec) | set_vec;
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           irq_mask <= '0;
    else if (we && waddr == ADDR_MASK)    irq_mask <= wdata_low;
  end

  // Output registers; 0xE/0xF are never shadowed by an output channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_regs <= '0;
    end else if (we && waddr < ADDR_MASK) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (waddr == 4'(NUM_IN + j)) out_regs[j*WIDTH +: WIDTH] <= wdata;
      end
    end
  end

  assign out_pins = out_regs;
  assign irq      = |(chg_flag & irq_mask);

  // Read mux over current state, so a same-cycle write is not yet visible
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (raddr == 4'(i)) rd_next = acc_flat[i*WIDTH +: WIDTH];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (raddr == 4'(NUM_IN + j)) rd_next = out_regs[j*WIDTH +: WIDTH];
    end
    if (raddr == ADDR_MASK) rd_next = WIDTH'(irq_mask);
    if (raddr == ADDR_FLAG) rd_next = WIDTH'(chg_flag);
  end

  // Registered read data, held while re is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rd_next;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - directed self-checking bench for gpio_bank
module tb_gpio_bank;

`ifdef GPIO_DEBOUNCE_EN
  localparam int IN_LAT = 19;
`else
  localparam int IN_LAT = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [3:0]  raddr;
  logic [31:0] rdata;
  logic [63:0] in_pins;
  logic [63:0] out_pins;
  logic [1:0]  chg_flag;
  logic        irq;

  int n_checks;
  int n_pass;
  logic [31:0] rv;

  gpio_bank #(
    .NUM_IN(2), .NUM_OUT(2), .WIDTH(32), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .in_pins(in_pins),
    .out_pins(out_pins), .chg_flag(chg_flag), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    re = 1'b1; raddr = a;
    tick(1);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic set_in(input int ch, input logic [31:0] v);
    in_pins[ch*32 +: 32] = v;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; we = 1'b1; waddr = 4'd2; wdata = 32'hFFFF_FFFF;
    re = 1'b1; raddr = 4'd2; in_pins = {32'h0, 32'h0000_005A};

    tick(4);
    check("rst_out_pins", out_pins[31:0], 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_chg_flag", {30'h0, chg_flag}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    we = 1'b0; re = 1'b1; raddr = 4'd0;
    rst_n = 1'b1;
    tick(1);
    check("fill_read_first", rdata, 32'h0);
    tick(IN_LAT - 1);
    check("fill_read_last_zero", rdata, 32'h0);
    tick(1);
    check("fill_read_value", rdata, 32'h0000_005A);
    re = 1'b0;
    check("fill_flag", {30'h0, chg_flag}, 32'h1);
    wr(4'hF, 32'h3);
    check("w1c_after_fill", {30'h0, chg_flag}, 32'h0);

    wr(4'd2, 32'hDEAD_BEEF);
    check("out0_pins", out_pins[31:0], 32'hDEAD_BEEF);
    rd(4'd2, rv);
    check("out0_read", rv, 32'hDEAD_BEEF);
    wr(4'd3, 32'h1234_5678);
    check("out1_pins", out_pins[63:32], 32'h1234_5678);
    check("out0_kept", out_pins[31:0], 32'hDEAD_BEEF);
    rd(4'd9, rv);
    check("read_unmapped", rv, 32'h0);
    wr(4'd5, 32'hFFFF_FFFF);
    rd(4'd5, rv);
    check("write_unmapped_read", rv, 32'h0);
    check("write_unmapped_out", out_pins, 64'h1234_5678_DEAD_BEEF);

    we = 1'b1; waddr = 4'd2; wdata = 32'hCAFE_F00D;
    re = 1'b1; raddr = 4'd2;
    tick(1);
    we = 1'b0; re = 1'b0;
    check("rw_same_old", rdata, 32'hDEAD_BEEF);
    check("rw_same_pins", out_pins[31:0], 32'hCAFE_F00D);
    tick(2);
    check("rdata_held", rdata, 32'hDEAD_BEEF);

    set_in(0, 32'd2);
    tick(IN_LAT - 1);
    check("in0_flag_early", {30'h0, chg_flag}, 32'h0);
    tick(1);
    check("in0_flag_set", {30'h0, chg_flag}, 32'h1);
    rd(4'd0, rv);
    check("in0_read", rv, 32'd2);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(4'hE, 32'h1);
    check("irq_unmasked", {31'h0, irq}, 32'h1);
    wr(4'hE, 32'hFFFF_FFFF);
    rd(4'hE, rv);
    check("mask_upper_ignored", rv, 32'h3);
    wr(4'hE, 32'h1);
    rd(4'hF, rv);
    check("flag_read", rv, 32'h1);
    wr(4'hF, 32'h1);
    check("flag_w1c", {30'h0, chg_flag}, 32'h0);
    check("irq_after_clear", {31'h0, irq}, 32'h0);

    set_in(0, 32'd7);
    tick(IN_LAT);
    check("coll_pre_set", {30'h0, chg_flag}, 32'h1);
    set_in(0, 32'd9);
    tick(IN_LAT - 1);
    wr(4'hF, 32'h1);
    check("coll_set_wins", {30'h0, chg_flag}, 32'h1);
    check("coll_irq", {31'h0, irq}, 32'h1);
    wr(4'hF, 32'h1);
    check("coll_clear_after", {30'h0, chg_flag}, 32'h0);

    set_in(1, 32'h0000_A5A5);
    tick(IN_LAT);
    check("in1_flag", {30'h0, chg_flag}, 32'h2);
    check("in1_irq_masked", {31'h0, irq}, 32'h0);
    rd(4'd1, rv);
    check("in1_read", rv, 32'h0000_A5A5);
    wr(4'hF, 32'h2);
    check("in1_w1c", {30'h0, chg_flag}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    set_in(1, 32'h0000_FFFF);
    tick(5);
    set_in(1, 32'h0000_A5A5);
    tick(40);
    check("db_glitch_flag", {30'h0, chg_flag}, 32'h0);
    rd(4'd1, rv);
    check("db_glitch_acc", rv, 32'h0000_A5A5);

    set_in(1, 32'h0000_1234);
    tick(18);
    check("db_hold_early", {30'h0, chg_flag}, 32'h0);
    tick(1);
    check("db_hold_19", {30'h0, chg_flag}, 32'h2);
    rd(4'd1, rv);
    check("db_hold_acc", rv, 32'h0000_1234);

    set_in(1, 32'h0000_4321);
    tick(13);
    rst_n = 1'b0;
    tick(1);
    check("db_rst_flag", {30'h0, chg_flag}, 32'h0);
    rst_n = 1'b1;
    tick(18);
    check("db_rst_early", {31'h0, chg_flag[1]}, 32'h0);
    tick(1);
    check("db_rst_restart", {31'h0, chg_flag[1]}, 32'h1);
    rd(4'd1, rv);
    check("db_rst_acc", rv, 32'h0000_4321);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
